ram_banked_clr: RTL and testbench



---
 rtl/ram_banked_clr.sv | 126 ++++++++++++
 tb/tb_ram_banked_clr.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ram_banked_clr.sv
// Banked single-port RAM that zeroes itself after reset, with a
// selectable combinational or registered (read-first) read port.
module ram_banked_clr #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 9,
    parameter int BANK_BITS = 3,
    parameter int READ_REG  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 load,
    output logic [WIDTH-1:0]     out,
    output logic                 busy
);
    localparam int NBANK    = 1 << BANK_BITS;
    localparam int OFF_BITS = ADDR_BITS - BANK_BITS;
    localparam int SEL_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int BDEPTH   = 1 << OFF_BITS;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                 state_reg;
    logic [ADDR_BITS-1:0]   clr_addr_reg;
    logic                   busy_reg;

    logic [ADDR_BITS-1:0]   wr_addr;
    logic [WIDTH-1:0]       wr_data;
    logic                   wr_en;
    logic [SEL_W-1:0]       wr_sel;
    logic [SEL_W-1:0]       rd_sel;
    logic [OFF_BITS-1:0]    wr_off;
    logic [OFF_BITS-1:0]    rd_off;
    logic [NBANK-1:0]       bank_we;
    logic [WIDTH-1:0]       rd_data [NBANK];

    // Bank index is the top field; with a single bank the shift leaves zero.
    function automatic logic [SEL_W-1:0] bank_of(input logic [ADDR_BITS-1:0] a);
        logic [ADDR_BITS-1:0] s;
        s = a >> OFF_BITS;
        return s[SEL_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= CLEAR;
            clr_addr_reg <= '0;
            busy_reg     <= 1'b1;
        end else begin
            case (state_reg)
                CLEAR: begin
                    if (clr_addr_reg == '1) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        clr_addr_reg <= clr_addr_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // The clear sequencer owns the write port until it finishes.
    always_comb begin
        wr_addr = addr;
        wr_data = in;
        wr_en   = load & ~reset;
        if (state_reg == CLEAR) begin
            wr_addr = clr_addr_reg;
            wr_data = '0;
            wr_en   = ~reset;
        end
    end

    assign wr_sel = bank_of(wr_addr);
    assign rd_sel = bank_of(addr);
    assign wr_off = wr_addr[OFF_BITS-1:0];
    assign rd_off = addr[OFF_BITS-1:0];
    assign busy   = busy_reg;

    generate
        for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
            logic [WIDTH-1:0] mem [BDEPTH];

            assign bank_we[gi] = wr_en && (wr_sel == SEL_W'(gi));

            always_ff @(posedge clk) begin
                if (bank_we[gi]) begin
                    mem[wr_off] <= wr_data;
                end
            end

            if (READ_REG != 0) begin : g_rreg
                logic [WIDTH-1:0] rd_q_reg;
                always_ff @(posedge clk) begin
                    rd_q_reg <= mem[rd_off];
                end
                assign rd_data[gi] = rd_q_reg;
            end else begin : g_rcomb
                assign rd_data[gi] = mem[rd_off];
            end
        end

        if (READ_REG != 0) begin : g_out_reg
            logic [SEL_W-1:0] rd_sel_reg;
            logic             out_en_reg;
            // Output stays zero until a read was taken with the RAM fully cleared.
            always_ff @(posedge clk) begin
                if (reset) begin
                    out_en_reg <= 1'b0;
                end else begin
                    out_en_reg <= (state_reg == IDLE);
                end
                rd_sel_reg <= rd_sel;
            end
            assign out = out_en_reg ? rd_data[rd_sel_reg] : '0;
        end else begin : g_out_comb
            assign out = busy_reg ? '0 : rd_data[rd_sel];
        end
    endgenerate
endmodule

// File: tb/tb_ram_banked_clr.sv
// Bench for ram_banked_clr: four configurations driven with directed
// vectors, checked every cycle against a flat-array model.
module tb_ram_banked_clr;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_l;
    logic [8:0]  addr_l;
    logic        load_l;
    logic [7:0]  in_s;
    logic [3:0]  addr_s;
    logic        load_s;
    logic [15:0] out0, out1;
    logic [7:0]  out2, out3;
    logic        busy0, busy1, busy2, busy3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ram_banked_clr #(.WIDTH(16), .ADDR_BITS(9), .BANK_BITS(3), .READ_REG(0)) dut0 (
        .clk(clk), .reset(reset), .in(in_l), .addr(addr_l), .load(load_l), .out(out0), .busy(busy0));
    ram_banked_clr #(.WIDTH(16), .ADDR_BITS(9), .BANK_BITS(3), .READ_REG(1)) dut1 (
        .clk(clk), .reset(reset), .in(in_l), .addr(addr_l), .load(load_l), .out(out1), .busy(busy1));
    ram_banked_clr #(.WIDTH(8), .ADDR_BITS(4), .BANK_BITS(0), .READ_REG(0)) dut2 (
        .clk(clk), .reset(reset), .in(in_s), .addr(addr_s), .load(load_s), .out(out2), .busy(busy2));
    ram_banked_clr #(.WIDTH(8), .ADDR_BITS(4), .BANK_BITS(2), .READ_REG(1)) dut3 (
        .clk(clk), .reset(reset), .in(in_s), .addr(addr_s), .load(load_s), .out(out3), .busy(busy3));

    // Model: a flat array plus a count of clear edges still owed.
    bit          model_ok = 1'b0;
    int          clr_l, clr_s;
    logic [15:0] mem_l [512];
    logic [7:0]  mem_s [16];
    logic [15:0] reg_l;
    logic [7:0]  reg_s;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            clr_l = 512; clr_s = 16; reg_l = '0; reg_s = '0; model_ok = 1'b1;
        end else if (model_ok) begin
            if (clr_l > 0) begin
                reg_l = '0;
                clr_l--;
                if (clr_l == 0) foreach (mem_l[i]) mem_l[i] = '0;
            end else begin
                reg_l = mem_l[addr_l];
                if (load_l) mem_l[addr_l] = in_l;
            end
            if (clr_s > 0) begin
                reg_s = '0;
                clr_s--;
                if (clr_s == 0) foreach (mem_s[i]) mem_s[i] = '0;
            end else begin
                reg_s = mem_s[addr_s];
                if (load_s) mem_s[addr_s] = in_s;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            chk("busy0", 32'(busy0), 32'(clr_l > 0));
            chk("busy1", 32'(busy1), 32'(clr_l > 0));
            chk("busy2", 32'(busy2), 32'(clr_s > 0));
            chk("busy3", 32'(busy3), 32'(clr_s > 0));
            chk("out0_comb", 32'(out0), (clr_l > 0) ? 32'd0 : 32'(mem_l[addr_l]));
            chk("out1_reg", 32'(out1), 32'(reg_l));
            chk("out2_comb", 32'(out2), (clr_s > 0) ? 32'd0 : 32'(mem_s[addr_s]));
            chk("out3_reg", 32'(out3), 32'(reg_s));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Runs out a clear from release; returns edges until each size goes idle.
    task automatic run_clear(output int n_l, output int n_s);
        n_l = 0; n_s = 0;
        reset = 1'b0;
        do begin
            if (n_l == 10) begin
                load_l = 1'b1; addr_l = 9'd5; in_l = 16'hBEEF;
                load_s = 1'b1; addr_s = 4'd5; in_s = 8'hEE;
            end else begin
                load_l = 1'b0; load_s = 1'b0;
            end
            step();
            n_l++;
            if (!busy2 && n_s == 0) n_s = n_l;
        end while (busy0 && n_l < 2000);
        load_l = 1'b0; load_s = 1'b0;
    endtask

    task automatic read_sweep();
        for (int a = 0; a < 512; a++) begin
            addr_l = 9'(a);
            addr_s = 4'(a);
            step();
        end
    endtask

    initial begin
        int n_l, n_s;
        reset = 1'b1; load_l = 1'b0; load_s = 1'b0;
        in_l = '0; addr_l = '0; in_s = '0; addr_s = '0;
        repeat (3) step();
        chk("reset_busy", 32'(busy0 & busy1 & busy2 & busy3), 32'd1);
        chk("reset_out1", 32'(out1), 32'd0);
        chk("reset_out3", 32'(out3), 32'd0);

        run_clear(n_l, n_s);
        chk("clear_len_512", 32'(n_l), 32'd512);
        chk("clear_len_16", 32'(n_s), 32'd16);
        read_sweep();
        addr_l = 9'd5; step();
        chk("write_during_clear0", 32'(out0), 32'd0);
        chk("write_during_clear1", 32'(out1), 32'd0);

        // bank decode on the combinational instance
        addr_l = 9'h040; in_l = 16'h1234; load_l = 1'b1;
        #1;
        chk("bank_strobe", 32'(dut0.bank_we), 32'h02);
        chk("old_before_edge", 32'(out0), 32'd0);
        step(); load_l = 1'b0; #1;
        chk("bank1_read", 32'(out0), 32'h1234);
        addr_l = 9'h000; in_l = 16'h5678; load_l = 1'b1;
        step(); load_l = 1'b0; #1;
        chk("bank0_read", 32'(out0), 32'h5678);
        addr_l = 9'h040; #1;
        chk("bank1_reread", 32'(out0), 32'h1234);
        addr_l = 9'h1C0; #1;
        chk("bank7_zero", 32'(out0), 32'd0);
        step();

        // registered read-first
        addr_l = 9'h00A; in_l = 16'h0001; load_l = 1'b1;
        step(); load_l = 1'b0;
        step();
        in_l = 16'h00FF; load_l = 1'b1;
        step(); load_l = 1'b0; #1;
        chk("read_first_old", 32'(out1), 32'h0001);
        step();
        chk("read_first_new", 32'(out1), 32'h00FF);

        // reset in the middle of a clear
        reset = 1'b1; step();
        reset = 1'b0;
        repeat (200) step();
        chk("midclear_busy", 32'(busy0), 32'd1);
        reset = 1'b1; step();
        run_clear(n_l, n_s);
        chk("reclear_len_512", 32'(n_l), 32'd512);
        chk("reclear_len_16", 32'(n_s), 32'd16);
        read_sweep();
        addr_l = 9'h00A; #1;
        chk("reclear_zero", 32'(out0), 32'd0);

        // small configurations: distinct data at every address
        for (int a = 0; a < 16; a++) begin
            addr_s = 4'(a); in_s = 8'hA5 + 8'(a); load_s = 1'b1;
            step();
        end
        load_s = 1'b0;
        for (int a = 0; a < 16; a++) begin
            addr_s = 4'(a);
            step();
            chk("small_b0", 32'(out2), 32'(8'hA5 + 8'(a)));
            chk("small_b2", 32'(out3), 32'(8'hA5 + 8'(a)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
